// File: rtl/uart_rx_os.sv
// Mid-bit-sampling UART receiver: 5..9 data bits, optional parity, 1..2 stop bits,
// with a first-word-fall-through receive FIFO and one-cycle error pulses.
module uart_rx_os #(
    parameter int unsigned CLK_DIV    = 434,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pin_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int unsigned DW = $clog2(CLK_DIV);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam logic [DW-1:0] HalfLoad = DW'(CLK_DIV / 2 - 1);
    localparam logic [DW-1:0] FullLoad = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } state_e;

    logic                 s1_q, s_q;
    state_e               state_q;
    logic [DW-1:0]        div_q;
    logic [3:0]           bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 perr_q, ferr_q;
    logic                 frame_err_q, parity_err_q, overrun_q;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_q, rd_q;
    logic [AW:0]          cnt_q;
    logic [DATA_BITS-1:0] last_q;

    logic tick, full, pop, push, last_stop, ferr_now, good, par_ones, par_bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b1;
            s_q  <= 1'b1;
        end else begin
            s1_q <= pin_i;
            s_q  <= s1_q;
        end
    end

    always_comb begin
        tick      = (div_q == '0);
        full      = (cnt_q == (AW + 1)'(FIFO_DEPTH));
        valid_o   = (cnt_q != '0);
        pop       = valid_o & ready_i;
        last_stop = (state_q == StStop) && tick && (bit_q == 4'(STOP_BITS - 1));
        ferr_now  = ferr_q | ~s_q;
        good      = last_stop & ~ferr_now & ~perr_q;
        // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
        push      = good & (~full | pop);
        par_ones  = ^{s_q, shift_q};
        par_bad   = (PARITY == 1) ? ~par_ones : par_ones;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            div_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_err_q  <= last_stop & ferr_now;
            parity_err_q <= last_stop & perr_q;
            overrun_q    <= good & full & ~pop;
            unique case (state_q)
                StIdle: begin
                    if (!s_q) begin
                        state_q <= StStart;
                        div_q   <= HalfLoad;
                        perr_q  <= 1'b0;
                        ferr_q  <= 1'b0;
                    end
                end
                StStart: begin
                    if (!tick) begin
                        div_q <= div_q - 1'b1;
                    end else if (s_q) begin
                        state_q <= StIdle;
                    end else begin
                        state_q <= StData;
                        div_q   <= FullLoad;
                        bit_q   <= '0;
                    end
                end
                StData: begin
                    if (!tick) begin
                        div_q <= div_q - 1'b1;
                    end else begin
                        div_q   <= FullLoad;
                        shift_q <= {s_q, shift_q[DATA_BITS-1:1]};
                        if (bit_q == 4'(DATA_BITS - 1)) begin
                            bit_q   <= '0;
                            state_q <= (PARITY != 0) ? StParity : StStop;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end
                StParity: begin
                    if (!tick) begin
                        div_q <= div_q - 1'b1;
                    end else begin
                        div_q   <= FullLoad;
                        bit_q   <= '0;
                        perr_q  <= par_bad;
                        state_q <= StStop;
                    end
                end
                StStop: begin
                    if (!tick) begin
                        div_q <= div_q - 1'b1;
                    end else begin
                        div_q <= FullLoad;
                        if (!s_q) begin
                            ferr_q <= 1'b1;
                        end
                        if (bit_q == 4'(STOP_BITS - 1)) begin
                            bit_q   <= '0;
                            state_q <= ferr_now ? StBreak : StIdle;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end
                StBreak: begin
                    if (s_q) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            if (push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q   <= rd_q + 1'b1;
                last_q <= mem_q[rd_q];
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Holding the last popped word keeps data stable once the FIFO drains.
    assign data_o       = valid_o ? mem_q[rd_q] : last_q;
    assign frame_err_o  = frame_err_q;
    assign parity_err_o = parity_err_q;
    assign overrun_o    = overrun_q;
    assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os (16 clocks/bit, 8 data bits, even parity, 2 stop bits).
module tb_uart_rx_os;

    localparam int unsigned DIV   = 16;
    localparam int unsigned DEPTH = 4;

    logic       clk, rst, pin, ready;
    logic [7:0] data;
    logic       valid, frame_err, parity_err, overrun, busy;

    uart_rx_os #(
        .CLK_DIV   (DIV),
        .DATA_BITS (8),
        .PARITY    (2),
        .STOP_BITS (2),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pin_i       (pin),
        .data_o      (data),
        .valid_o     (valid),
        .ready_i     (ready),
        .frame_err_o (frame_err),
        .parity_err_o(parity_err),
        .overrun_o   (overrun),
        .busy_o      (busy)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int exp_ferr = 0, exp_perr = 0, exp_ovr = 0;
    int act_ferr = 0, act_perr = 0, act_ovr = 0;
    bit rr_en = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog act=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: counts pulse cycles and checks each popped word against the scoreboard.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (frame_err)  act_ferr++;
                if (parity_err) act_perr++;
                if (overrun)    act_ovr++;
                if (valid && ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pop act=%0h required=none", data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pop_data", {24'h0, data}, {24'h0, e});
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rr_en) ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        if (n > 0) #1;
    endtask

    task automatic drive_bit(input logic b);
        pin = b;
        wait_cyc(DIV);
    endtask

    // Frame-level reference: outcome decided from data, parity bit and stop levels.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic st1,
                              input logic st2, input int gap, input int brk);
        bit pe, fe;
        pe = ($countones({d, pbit}) % 2) != 0;
        fe = !st1 || !st2;
        if (fe) exp_ferr++;
        if (pe) exp_perr++;
        if (!fe && !pe) begin
            if (!ready && exp_q.size() >= DEPTH) exp_ovr++;
            else exp_q.push_back(d);
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(pbit);
        drive_bit(st1);
        drive_bit(st2);
        if (brk > 0) begin
            wait_cyc(brk);
            chk("busy_in_break", {31'h0, busy}, 32'h1);
        end
        pin = 1'b1;
        wait_cyc(gap);
    endtask

    task automatic drain();
        int n;
        n = 0;
        ready = 1'b1;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_left", exp_q.size(), 0);
        wait_cyc(3);
        if (!rr_en) chk("valid_after_drain", {31'h0, valid}, 32'h0);
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_frame_err_cnt"}, act_ferr, exp_ferr);
        chk({tag, "_parity_err_cnt"}, act_perr, exp_perr);
        chk({tag, "_overrun_cnt"}, act_ovr, exp_ovr);
    endtask

    initial begin
        int lat;
        logic [7:0] d;
        logic pb, s1, s2;
        int er;

        rst = 1'b0;
        pin = 1'b1;
        ready = 1'b0;
        wait_cyc(4);
        chk("rst_valid", {31'h0, valid}, 32'h0);
        chk("rst_data", {24'h0, data}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_ferr", {31'h0, frame_err}, 32'h0);
        chk("rst_perr", {31'h0, parity_err}, 32'h0);
        chk("rst_ovr", {31'h0, overrun}, 32'h0);
        rst = 1'b1;
        wait_cyc(5);

        // Latency: pin falls, t0 three edges later, last stop at t0+184, valid after t0+184.
        lat = -1;
        fork
            send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 20, 0);
            begin
                for (int n = 1; n <= 400; n++) begin
                    @(posedge clk);
                    #1;
                    if (valid && lat < 0) lat = n;
                end
            end
        join
        checks++;
        if (lat < 186 || lat > 188) begin
            errors++;
            $display("FAIL latency act=%0d required=187+-1", lat);
        end
        chk("head_a5", {24'h0, data}, 32'hA5);
        drain();
        check_flags("a5");

        // Back-to-back frames held in the FIFO.
        ready = 1'b0;
        send_frame(8'h00, 1'b0, 1'b1, 1'b1, 0, 0);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b1, 0, 0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 10, 0);
        chk("b2b_valid", {31'h0, valid}, 32'h1);
        chk("b2b_head", {24'h0, data}, 32'h00);
        drain();

        // Glitch shorter than half a bit is rejected.
        pin = 1'b0;
        wait_cyc(5);
        pin = 1'b1;
        wait_cyc(12);
        chk("glitch_busy", {31'h0, busy}, 32'h0);
        chk("glitch_valid", {31'h0, valid}, 32'h0);
        check_flags("glitch");

        // Even parity on 0x07: wrong parity bit, then correct one.
        send_frame(8'h07, 1'b0, 1'b1, 1'b1, 10, 0);
        check_flags("par_bad");
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 10, 0);
        drain();
        check_flags("par_good");

        // Low stop bit followed by a long break, then a normal frame.
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 0, 400);
        wait_cyc(6);
        chk("break_busy_after", {31'h0, busy}, 32'h0);
        send_frame(8'h81, 1'b0, 1'b1, 1'b1, 10, 0);
        drain();
        check_flags("break");

        // Overrun: five good frames into a four-entry FIFO with ready low.
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom_range(0, 255));
            send_frame(d, ^d, 1'b1, 1'b1, 0, 0);
        end
        wait_cyc(10);
        check_flags("overrun");
        drain();

        // Randomised frames with random ready and occasional errors.
        rr_en = 1;
        for (int i = 0; i < 40; i++) begin
            d  = 8'($urandom_range(0, 255));
            pb = (^d) ^ ($urandom_range(0, 7) == 0);
            er = $urandom_range(0, 7);
            s1 = (er != 0);
            s2 = (er != 1);
            send_frame(d, pb, s1, s2, $urandom_range(2, 15), 0);
        end
        drain();
        rr_en = 0;
        ready = 1'b1;
        wait_cyc(4);
        chk("rand_valid_end", {31'h0, valid}, 32'h0);
        check_flags("random");

        // Reset mid-frame flushes the FIFO and drops the partial frame silently.
        ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 1'b1, 0, 0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1, 4, 0);
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        rst = 1'b0;
        #1;
        exp_q.delete();
        chk("midrst_valid", {31'h0, valid}, 32'h0);
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_data", {24'h0, data}, 32'h0);
        pin = 1'b1;
        wait_cyc(3);
        rst = 1'b1;
        wait_cyc(30);
        chk("postrst_valid", {31'h0, valid}, 32'h0);
        ready = 1'b1;
        send_frame(8'hC3, 1'b0, 1'b1, 1'b1, 10, 0);
        drain();
        check_flags("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
